// File: rtl/ram_rd_pkg.sv
// Shared constants and types for the RAM burst read path.
package ram_rd_pkg;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned RD_LAT = 2;
  localparam int unsigned PIPE_D = RD_LAT + 1;
  localparam int unsigned LEN_W  = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic valid;
    logic last;
  } tag_t;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } beat_t;

  // Read addresses wrap modulo the RAM size.
  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/ram_rd_buf.sv
// Small synchronous FIFO holding returned RAM beats; same-edge push and pop both apply.
module ram_rd_buf
  import ram_rd_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  beat_t            push_beat_i,
  input  logic             pop_i,
  output logic             valid_o,
  output beat_t            head_o,
  output logic [CNT_W-1:0] count_o
);

  beat_t            mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    do_pop   = pop_i && valid_q;
    do_push  = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    if (do_push && !do_pop) count_d = count_q + CNT_W'(1);
    if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
    valid_d = (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      if (do_push) mem_q[wr_ptr_q] <= push_beat_i;
    end
  end

  assign valid_o = valid_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ram_burst_reader.sv
// Burst read sequencer: issues RAM addresses under credit, tracks read latency,
// and streams returned bytes out through a small buffer.
module ram_burst_reader
  import ram_rd_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int unsigned OUT_W = $clog2(BUF_DEPTH + PIPE_D + 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  tag_t              pipe_q [PIPE_D];
  tag_t              pipe_d [PIPE_D];

  tag_t              issue_tag;
  logic              buf_valid;
  beat_t             buf_head;
  logic [CNT_W-1:0]  buf_count;
  logic              pop;
  logic              push;
  beat_t             push_beat;
  logic [OUT_W-1:0]  inflight;
  logic [OUT_W-1:0]  outstanding;
  logic              credit;

  always_comb begin
    pop       = buf_valid && out_ready;
    inflight  = '0;
    for (int i = 0; i < int'(PIPE_D); i++) inflight = inflight + OUT_W'(pipe_q[i].valid);
    outstanding = OUT_W'(buf_count) + inflight;
    // Issue only if the word is guaranteed a buffer slot when it returns.
    credit    = (outstanding - OUT_W'(pop)) < OUT_W'(BUF_DEPTH);

    issue_tag  = '0;
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    ram_addr_d = ram_addr_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_len == '0) begin
            done_d = 1'b1;
          end else begin
            ram_addr_d      = cmd_addr;
            addr_d          = addr_inc(cmd_addr);
            rem_d           = cmd_len - LEN_W'(1);
            issue_tag.valid = 1'b1;
            issue_tag.last  = (cmd_len == LEN_W'(1));
            state_d         = (cmd_len == LEN_W'(1)) ? DRAIN : ISSUE;
          end
        end
      end
      ISSUE: begin
        if (credit) begin
          ram_addr_d      = addr_q;
          addr_d          = addr_inc(addr_q);
          rem_d           = rem_q - LEN_W'(1);
          issue_tag.valid = 1'b1;
          issue_tag.last  = (rem_q == LEN_W'(1));
          if (rem_q == LEN_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((inflight == '0) && pop && buf_head.last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    pipe_d[0] = issue_tag;
    for (int i = 1; i < int'(PIPE_D); i++) pipe_d[i] = pipe_q[i-1];

    push           = pipe_q[PIPE_D-1].valid;
    push_beat.last = pipe_q[PIPE_D-1].last;
    push_beat.data = ram_q;

    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      ram_addr_q  <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < int'(PIPE_D); i++) pipe_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      ram_addr_q  <= ram_addr_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      for (int i = 0; i < int'(PIPE_D); i++) pipe_q[i] <= pipe_d[i];
    end
  end

  ram_rd_buf #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_beat_i (push_beat),
    .pop_i       (pop),
    .valid_o     (buf_valid),
    .head_o      (buf_head),
    .count_o     (buf_count)
  );

  assign cmd_ready = cmd_ready_q;
  assign ram_addr  = ram_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = buf_valid;
  assign out_data  = buf_head.data;
  assign out_last  = buf_head.last;

endmodule

// File: tb/tb_ram_burst_reader.sv
// End-to-end bench: burst reader driving a 2-cycle-latency RAM model, checked against a burst-level reference.
module tb_ram_burst_reader;
  import ram_rd_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, cmd_valid, cmd_ready, out_valid, out_ready, out_last, busy, done;
  logic [ADDR_W-1:0] cmd_addr, ram_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic [DATA_W-1:0] ram_q, out_data;

  int errors = 0;
  int checks = 0;

  ram_burst_reader #(.BUF_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .ram_addr  (ram_addr),
    .ram_q     (ram_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  // RAM read port: address register then q register.
  logic [DATA_W-1:0] mem [128];
  logic [ADDR_W-1:0] ram_a_q;
  always @(posedge clk) begin
    ram_a_q <= ram_addr;
    ram_q   <= mem[ram_a_q];
  end

  // Stream monitor: accepted beats, issued addresses, outstanding words, done pulses.
  logic [8:0]        got[$];
  int                issued, accepted, max_out, done_cnt, last_cnt;
  logic [ADDR_W-1:0] prev_addr;
  always @(posedge clk) begin
    if (!rst) begin
      if (ram_addr !== prev_addr) issued++;
      if (issued - accepted > max_out) max_out = issued - accepted;
      if (out_valid && out_ready) begin
        got.push_back({out_last, out_data});
        accepted++;
        if (out_last) last_cnt++;
      end
      if (done) done_cnt++;
    end
    prev_addr = ram_addr;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got.delete();
    issued = 0; accepted = 0; max_out = 0; done_cnt = 0; last_cnt = 0;
  endtask

  task automatic start_cmd(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
    check("cmd_ready before accept", 32'(cmd_ready), 32'd1);
    cmd_addr  = a;
    cmd_len   = l;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max, input bit rnd);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      tick();
      seen = done;
    end
    out_ready = 1'b1;
    check({tag, " done seen"}, 32'(seen), 32'd1);
  endtask

  // Reference: a burst returns mem[(addr+k) mod 128] for k=0..len-1, last on the final one.
  task automatic check_beats(input string tag, input int addr, input int len);
    logic [ADDR_W-1:0] a;
    logic [31:0]       exp, obs;
    check({tag, " beat count"}, 32'(got.size()), 32'(len));
    for (int k = 0; k < len; k++) begin
      a   = ADDR_W'(addr + k);
      exp = 32'({(k == len - 1), mem[a]});
      obs = (k < got.size()) ? 32'(got[k]) : 32'hDEAD_BEEF;
      check($sformatf("%s beat %0d", tag, k), obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'(i) ^ 8'h5A;
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; out_ready = 1'b1;
    clear_mon();

    // Reset values
    tick(); tick(); tick();
    check("rst cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst ram_addr",  32'(ram_addr),  32'd0);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_data",  32'(out_data),  32'd0);
    check("rst out_last",  32'(out_last),  32'd0);
    check("rst busy",      32'(busy),      32'd0);
    check("rst done",      32'(done),      32'd0);
    rst = 1'b0;
    tick();

    // Basic burst, cycle-exact
    clear_mon();
    start_cmd(7'h10, 8'd4);
    check("t1 ram_addr E0",  32'(ram_addr),  32'h10);
    check("t1 busy E0",      32'(busy),      32'd1);
    check("t1 cmd_ready E0", 32'(cmd_ready), 32'd0);
    check("t1 valid E0",     32'(out_valid), 32'd0);
    tick(); check("t1 valid E1", 32'(out_valid), 32'd0);
    tick(); check("t1 valid E2", 32'(out_valid), 32'd0);
    tick();
    check("t1 valid E3", 32'(out_valid), 32'd1);
    check("t1 data0",    32'(out_data),  32'h4A);
    check("t1 last0",    32'(out_last),  32'd0);
    tick(); check("t1 data1", 32'(out_data), 32'h4B); check("t1 last1", 32'(out_last), 32'd0);
    tick(); check("t1 data2", 32'(out_data), 32'h48); check("t1 last2", 32'(out_last), 32'd0);
    tick(); check("t1 data3", 32'(out_data), 32'h49); check("t1 last3", 32'(out_last), 32'd1);
    tick();
    check("t1 done",       32'(done),      32'd1);
    check("t1 cmd_ready",  32'(cmd_ready), 32'd1);
    check("t1 busy end",   32'(busy),      32'd0);
    check("t1 valid end",  32'(out_valid), 32'd0);
    tick();
    check("t1 done drop",  32'(done),      32'd0);
    check_beats("t1", 'h10, 4);
    check("t1 done pulses", 32'(done_cnt), 32'd1);
    check("t1 last count",  32'(last_cnt), 32'd1);

    // Address wrap
    clear_mon();
    start_cmd(7'h7E, 8'd4);
    check("t2 addr0", 32'(ram_addr), 32'h7E);
    tick(); check("t2 addr1", 32'(ram_addr), 32'h7F);
    tick(); check("t2 addr2", 32'(ram_addr), 32'h00);
    tick(); check("t2 addr3", 32'(ram_addr), 32'h01);
    wait_done("t2", 50, 1'b0);
    tick();
    check_beats("t2", 'h7E, 4);

    // Backpressure holds issue at the credit limit
    clear_mon();
    out_ready = 1'b0;
    start_cmd(7'h20, 8'd16);
    for (int i = 0; i < 12; i++) tick();
    check("t3 issued under stall", 32'(issued),   32'd4);
    check("t3 ram_addr held",      32'(ram_addr), 32'h23);
    out_ready = 1'b1;
    wait_done("t3", 100, 1'b0);
    tick();
    check_beats("t3", 'h20, 16);
    check("t3 max outstanding ok", 32'(max_out <= 4), 32'd1);

    // Full-length burst with random backpressure and random memory
    for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
    clear_mon();
    start_cmd(7'h40, 8'd128);
    wait_done("t4", 3000, 1'b1);
    tick();
    check_beats("t4", 'h40, 128);
    check("t4 last count",         32'(last_cnt), 32'd1);
    check("t4 done pulses",        32'(done_cnt), 32'd1);
    check("t4 max outstanding ok", 32'(max_out <= 4), 32'd1);

    // Zero-length command
    clear_mon();
    start_cmd(7'h05, 8'd0);
    check("t5 done",      32'(done),      32'd1);
    check("t5 cmd_ready", 32'(cmd_ready), 32'd1);
    check("t5 busy",      32'(busy),      32'd0);
    check("t5 valid",     32'(out_valid), 32'd0);
    tick();
    check("t5 done drop", 32'(done),      32'd0);
    check("t5 valid2",    32'(out_valid), 32'd0);
    check("t5 beats",     32'(got.size()), 32'd0);

    // Reset mid-burst, then a clean short burst
    for (int i = 0; i < 128; i++) mem[i] = 8'(i) ^ 8'h5A;
    clear_mon();
    start_cmd(7'h00, 8'd20);
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    check("t6 valid",     32'(out_valid), 32'd0);
    check("t6 busy",      32'(busy),      32'd0);
    check("t6 cmd_ready", 32'(cmd_ready), 32'd1);
    check("t6 done",      32'(done),      32'd0);
    check("t6 ram_addr",  32'(ram_addr),  32'd0);
    rst = 1'b0;
    clear_mon();
    start_cmd(7'h50, 8'd2);
    wait_done("t6", 50, 1'b0);
    for (int i = 0; i < 6; i++) tick();
    check_beats("t6", 'h50, 2);
    check("t6 done pulses", 32'(done_cnt), 32'd1);
    check("t6 idle valid",  32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
